// File: rtl/waveform_seq_if.sv
// waveform_seq_if: refresh/playback control, DMA read and SPI DAC signals.
// Ports: refresh_* (buffer load), ram_* (DMA read), arm/loop/timer (play),
//        running/finished/loops_done/err (status), dac_* (SPI master).
interface waveform_seq_if #(
    parameter int DAC_WID      = 24,
    parameter int BUF_AMNT_WID = 11,
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16,
    parameter int TIMER_WID    = 32,
    parameter int LOOP_WID     = 16
);
    logic                    refresh_start;
    logic [RAM_WID-1:0]      start_addr;
    logic [BUF_AMNT_WID-1:0] word_amnt;
    logic                    refresh_finished;
    logic [RAM_WID-1:0]      ram_dma_addr;
    logic                    ram_read;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic                    ram_valid;
    logic                    arm;
    logic [LOOP_WID-1:0]     loop_count;
    logic [TIMER_WID-1:0]    time_to_wait;
    logic                    running;
    logic                    finished;
    logic [LOOP_WID-1:0]     loops_done;
    logic                    err;
    logic [DAC_WID-1:0]      dac_word;
    logic                    dac_arm;
    logic                    dac_finished;

    modport master (
        input  refresh_start, start_addr, word_amnt,
        input  ram_word, ram_valid,
        input  arm, loop_count, time_to_wait,
        input  dac_finished,
        output refresh_finished, ram_dma_addr, ram_read,
        output running, finished, loops_done, err,
        output dac_word, dac_arm
    );

    modport slave (
        output refresh_start, start_addr, word_amnt,
        output ram_word, ram_valid,
        output arm, loop_count, time_to_wait,
        output dac_finished,
        input  refresh_finished, ram_dma_addr, ram_read,
        input  running, finished, loops_done, err,
        input  dac_word, dac_arm
    );
endinterface

// File: rtl/waveform_seq.sv
// waveform_seq: loads samples from RAM over DMA, then plays them to an
// SPI DAC master with programmable spacing and finite/continuous looping.
// Ports: clk, rst_L (async active-low), io (waveform_seq_if.master).
module waveform_seq #(
    parameter int DAC_WID       = 24,
    parameter int WORD_WID      = 20,
    parameter logic [DAC_WID-WORD_WID-1:0] DAC_PREFIX = 4'b0001,
    parameter int BUF_AMNT_WID  = 11,
    parameter int RAM_WID       = 32,
    parameter int RAM_WORD_WID  = 16,
    parameter int RAM_WORD_INCR = 2,
    parameter int TIMER_WID     = 32,
    parameter int LOOP_WID      = 16
) (
    input logic            clk,
    input logic            rst_L,
    waveform_seq_if.master io
);
    localparam int HI_WID = WORD_WID - RAM_WORD_WID;

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, REF_DONE,
        SEND, WAIT_DAC, WAIT_TIMER, PLAY_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [RAM_WID-1:0]      addr_q, addr_d;
    logic [BUF_AMNT_WID-1:0] amnt_q, amnt_d;
    logic [BUF_AMNT_WID-1:0] idx_q, idx_d;
    logic [BUF_AMNT_WID-1:0] pidx_q, pidx_d;
    logic [RAM_WORD_WID-1:0] lo_q, lo_d;
    logic                    gap_q, gap_d;
    logic                    err_q, err_d;
    logic                    bval_q, bval_d;
    logic                    fin_q, fin_d;
    logic [LOOP_WID-1:0]     loop_q, loop_d;
    logic [LOOP_WID-1:0]     lpd_q, lpd_d;
    logic [TIMER_WID-1:0]    twait_q, twait_d;
    logic [TIMER_WID-1:0]    tmr_q, tmr_d;
    logic                    dac_arm_q, dac_arm_d;
    logic [DAC_WID-1:0]      dac_word_q, dac_word_d;

    logic [WORD_WID-1:0]     mem_q [2**BUF_AMNT_WID];
    logic                    wr_en;
    logic [WORD_WID-1:0]     wr_data;
    logic [WORD_WID-1:0]     rd_sample;
    logic [BUF_AMNT_WID-1:0] idx_nx;
    logic [LOOP_WID-1:0]     lpd_inc;
    logic                    last;
    logic                    unused_hi;

    generate
        if (HI_WID < RAM_WORD_WID) begin : g_hi_drop
            assign unused_hi = ^io.ram_word[RAM_WORD_WID-1:HI_WID];
        end else begin : g_hi_full
            assign unused_hi = 1'b0;
        end
    endgenerate

    assign rd_sample = mem_q[pidx_q];
    assign wr_data   = {io.ram_word[HI_WID-1:0], lo_q};
    assign idx_nx    = idx_q + BUF_AMNT_WID'(1);
    assign last      = (pidx_q == amnt_q - BUF_AMNT_WID'(1));
    // loops_done sticks at all-ones in continuous mode
    assign lpd_inc   = (lpd_q == '1) ? lpd_q : lpd_q + LOOP_WID'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        amnt_d     = amnt_q;
        idx_d      = idx_q;
        pidx_d     = pidx_q;
        lo_d       = lo_q;
        gap_d      = gap_q;
        err_d      = err_q;
        bval_d     = bval_q;
        fin_d      = fin_q;
        loop_d     = loop_q;
        lpd_d      = lpd_q;
        twait_d    = twait_q;
        tmr_d      = tmr_q;
        dac_arm_d  = dac_arm_q;
        dac_word_d = dac_word_q;
        wr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.refresh_start) begin
                    addr_d  = io.start_addr;
                    amnt_d  = io.word_amnt;
                    idx_d   = '0;
                    gap_d   = 1'b0;
                    bval_d  = 1'b0;
                    err_d   = (io.word_amnt == '0);
                    state_d = (io.word_amnt == '0) ? REF_DONE : RD_LO;
                end else if (io.arm) begin
                    if (!bval_q) begin
                        err_d   = 1'b1;
                        fin_d   = 1'b1;
                        state_d = PLAY_DONE;
                    end else begin
                        loop_d  = io.loop_count;
                        twait_d = io.time_to_wait;
                        lpd_d   = '0;
                        pidx_d  = '0;
                        state_d = SEND;
                    end
                end
            end
            RD_LO: begin
                // gap_q holds ram_read low for one cycle between words
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (io.ram_valid) begin
                    lo_d    = io.ram_word;
                    addr_d  = addr_q + RAM_WID'(RAM_WORD_INCR);
                    gap_d   = 1'b1;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (io.ram_valid) begin
                    wr_en   = 1'b1;
                    addr_d  = addr_q + RAM_WID'(RAM_WORD_INCR);
                    gap_d   = 1'b1;
                    idx_d   = idx_nx;
                    state_d = (idx_nx == amnt_q) ? REF_DONE : RD_LO;
                end
            end
            REF_DONE: begin
                bval_d = !err_q;
                if (!io.refresh_start) state_d = IDLE;
            end
            SEND: begin
                if (!io.arm) begin
                    state_d = PLAY_DONE;
                end else begin
                    dac_word_d = {DAC_PREFIX, rd_sample};
                    dac_arm_d  = 1'b1;
                    state_d    = WAIT_DAC;
                end
            end
            WAIT_DAC: begin
                if (io.dac_finished) begin
                    dac_arm_d = 1'b0;
                    pidx_d    = last ? '0 : pidx_q + BUF_AMNT_WID'(1);
                    if (last) lpd_d = lpd_inc;
                    // time_to_wait = cycles with dac_arm low; SEND is one
                    if (last && loop_q != '0 && lpd_inc == loop_q) begin
                        fin_d   = 1'b1;
                        state_d = PLAY_DONE;
                    end else if (!io.arm) begin
                        state_d = PLAY_DONE;
                    end else if (twait_q <= TIMER_WID'(1)) begin
                        state_d = SEND;
                    end else begin
                        tmr_d   = twait_q - TIMER_WID'(1);
                        state_d = WAIT_TIMER;
                    end
                end
            end
            WAIT_TIMER: begin
                if (!io.arm) begin
                    state_d = PLAY_DONE;
                end else if (tmr_q <= TIMER_WID'(1)) begin
                    state_d = SEND;
                end else begin
                    tmr_d = tmr_q - TIMER_WID'(1);
                end
            end
            PLAY_DONE: begin
                if (!io.arm) begin
                    fin_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            amnt_q     <= '0;
            idx_q      <= '0;
            pidx_q     <= '0;
            lo_q       <= '0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
            bval_q     <= 1'b0;
            fin_q      <= 1'b0;
            loop_q     <= '0;
            lpd_q      <= '0;
            twait_q    <= '0;
            tmr_q      <= '0;
            dac_arm_q  <= 1'b0;
            dac_word_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            amnt_q     <= amnt_d;
            idx_q      <= idx_d;
            pidx_q     <= pidx_d;
            lo_q       <= lo_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            bval_q     <= bval_d;
            fin_q      <= fin_d;
            loop_q     <= loop_d;
            lpd_q      <= lpd_d;
            twait_q    <= twait_d;
            tmr_q      <= tmr_d;
            dac_arm_q  <= dac_arm_d;
            dac_word_q <= dac_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q] <= wr_data;
    end

    assign io.ram_read = (state_q == RD_LO || state_q == RD_HI) && !gap_q;
    assign io.ram_dma_addr     = addr_q;
    assign io.refresh_finished = (state_q == REF_DONE);
    assign io.running  = (state_q == SEND) || (state_q == WAIT_DAC)
                      || (state_q == WAIT_TIMER);
    assign io.finished   = fin_q;
    assign io.loops_done = lpd_q;
    assign io.err        = err_q;
    assign io.dac_word   = dac_word_q;
    assign io.dac_arm    = dac_arm_q;
endmodule

// File: tb/tb_waveform_seq.sv
// tb_waveform_seq: directed bench for waveform_seq with RAM and DAC models.
// Ports: none; drives the DUT through a waveform_seq_if instance.
module tb_waveform_seq;
    logic clk = 1'b0;
    logic rst_L;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    waveform_seq_if ifc ();

    waveform_seq dut (
        .clk   (clk),
        .rst_L (rst_L),
        .io    (ifc.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rmem [8];
    logic [31:0] ram_base;
    int          ram_lat = 2;
    int          ram_cnt;
    logic [31:0] addr_log [$];
    logic [23:0] dac_log [$];
    int          rise_log [$];
    int          fin_log [$];
    int          dac_cnt;
    logic        dac_busy;

    // RAM: answers each read request after ram_lat cycles
    initial begin
        logic [31:0] off;
        ifc.ram_valid = 1'b0;
        ifc.ram_word  = '0;
        ram_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_L || !ifc.ram_read || ifc.ram_valid) begin
                ifc.ram_valid = 1'b0;
                ram_cnt = 0;
            end else begin
                ram_cnt++;
                if (ram_cnt >= ram_lat) begin
                    off = (ifc.ram_dma_addr - ram_base) >> 1;
                    ifc.ram_word  = rmem[off[2:0]];
                    ifc.ram_valid = 1'b1;
                    addr_log.push_back(ifc.ram_dma_addr);
                    ram_cnt = 0;
                end
            end
        end
    end

    // DAC: acks 10 cycles into each dac_arm, logging words and timing
    initial begin
        ifc.dac_finished = 1'b0;
        dac_busy = 1'b0;
        dac_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_L) begin
                ifc.dac_finished = 1'b0;
                dac_busy = 1'b0;
            end else if (ifc.dac_finished) begin
                ifc.dac_finished = 1'b0;
            end else if (ifc.dac_arm) begin
                if (!dac_busy) begin
                    dac_busy = 1'b1;
                    dac_cnt = 0;
                    dac_log.push_back(ifc.dac_word);
                    rise_log.push_back(cyc);
                end
                dac_cnt++;
                if (dac_cnt == 10) begin
                    ifc.dac_finished = 1'b1;
                    dac_busy = 1'b0;
                    fin_log.push_back(cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        dac_log.delete();
        rise_log.delete();
        fin_log.delete();
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (ifc.ram_read !== 1'b0 || ifc.refresh_finished !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd got %b%b want 00",
                     ifc.ram_read, ifc.refresh_finished);
        end
        checks++;
        if (ifc.running !== 1'b0 || ifc.finished !== 1'b0
            || ifc.err !== 1'b0 || ifc.dac_arm !== 1'b0) begin
            errors++;
            $display("FAIL rst_play got %b%b%b%b want 0000", ifc.running,
                     ifc.finished, ifc.err, ifc.dac_arm);
        end
        checks++;
        if (ifc.loops_done !== '0 || ifc.dac_word !== '0
            || ifc.ram_dma_addr !== '0) begin
            errors++;
            $display("FAIL rst_bus got %h %h %h want 0", ifc.loops_done,
                     ifc.dac_word, ifc.ram_dma_addr);
        end
        rst_L = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid_refresh();
        int n;
        clear_logs();
        ram_base = 32'h100;
        ram_lat = 20;
        ifc.start_addr = 32'h100;
        ifc.word_amnt = 11'd2;
        ifc.refresh_start = 1'b1;
        n = 0;
        while (!(ifc.ram_read === 1'b1 && ifc.ram_dma_addr === 32'h102)
               && n < 80) begin
            tick(1);
            n++;
        end
        checks++;
        if (ifc.ram_dma_addr !== 32'h102 || ifc.ram_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_hi got %h %b want 102 1",
                     ifc.ram_dma_addr, ifc.ram_read);
        end
        #3 rst_L = 1'b0;
        #1;
        checks++;
        if (ifc.ram_read !== 1'b0 || ifc.refresh_finished !== 1'b0
            || ifc.running !== 1'b0 || ifc.err !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got %b%b%b%b want 0000", ifc.ram_read,
                     ifc.refresh_finished, ifc.running, ifc.err);
        end
        ifc.refresh_start = 1'b0;
        ram_lat = 2;
        tick(1);
        rst_L = 1'b1;
        tick(1);
        ifc.loop_count = 16'd1;
        ifc.time_to_wait = 32'd0;
        ifc.arm = 1'b1;
        n = 0;
        while (ifc.finished !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (ifc.finished !== 1'b1 || ifc.err !== 1'b1) begin
            errors++;
            $display("FAIL mid_arm got fin=%b err=%b want 1 1",
                     ifc.finished, ifc.err);
        end
        checks++;
        if (dac_log.size() != 0) begin
            errors++;
            $display("FAIL mid_nodac got %0d want 0", dac_log.size());
        end
        ifc.arm = 1'b0;
        tick(2);
        checks++;
        if (ifc.finished !== 1'b0) begin
            errors++;
            $display("FAIL mid_fin_drop got %b want 0", ifc.finished);
        end
    endtask

    task automatic test_refresh();
        int n;
        clear_logs();
        ram_base = 32'h12340;
        rmem[0] = 16'h0001;
        rmem[1] = 16'h000A;
        rmem[2] = 16'h0002;
        rmem[3] = 16'h000B;
        rmem[4] = 16'h0003;
        rmem[5] = 16'h000C;
        ifc.start_addr = 32'h12340;
        ifc.word_amnt = 11'd3;
        ifc.refresh_start = 1'b1;
        n = 0;
        while (ifc.refresh_finished !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (ifc.refresh_finished !== 1'b1 || ifc.err !== 1'b0) begin
            errors++;
            $display("FAIL ref_done got %b err=%b want 1 0",
                     ifc.refresh_finished, ifc.err);
        end
        checks++;
        if (addr_log.size() != 6) begin
            errors++;
            $display("FAIL ref_nwords got %0d want 6", addr_log.size());
        end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== 32'h12340 + 32'(2 * i)) begin
                errors++;
                $display("FAIL ref_addr%0d got %h want %h", i, addr_log[i],
                         32'h12340 + 32'(2 * i));
            end
        end
        tick(5);
        checks++;
        if (ifc.refresh_finished !== 1'b1) begin
            errors++;
            $display("FAIL ref_hold got %b want 1", ifc.refresh_finished);
        end
        ifc.refresh_start = 1'b0;
        tick(1);
        checks++;
        if (ifc.refresh_finished !== 1'b0) begin
            errors++;
            $display("FAIL ref_drop got %b want 0", ifc.refresh_finished);
        end
    endtask

    task automatic test_play_loops();
        int n;
        int arm_cyc;
        logic [23:0] exp_w [3];
        exp_w[0] = 24'h1A0001;
        exp_w[1] = 24'h1B0002;
        exp_w[2] = 24'h1C0003;
        clear_logs();
        ifc.loop_count = 16'd2;
        ifc.time_to_wait = 32'd5;
        ifc.arm = 1'b1;
        arm_cyc = cyc;
        tick(3);
        checks++;
        if (ifc.running !== 1'b1) begin
            errors++;
            $display("FAIL play_running got %b want 1", ifc.running);
        end
        n = 0;
        while (ifc.finished !== 1'b1 && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (ifc.finished !== 1'b1 || ifc.running !== 1'b0) begin
            errors++;
            $display("FAIL play_fin got fin=%b run=%b want 1 0",
                     ifc.finished, ifc.running);
        end
        checks++;
        if (ifc.loops_done !== 16'd2) begin
            errors++;
            $display("FAIL play_loops got %0d want 2", ifc.loops_done);
        end
        checks++;
        if (dac_log.size() != 6) begin
            errors++;
            $display("FAIL play_nxfer got %0d want 6", dac_log.size());
        end
        for (int i = 0; i < dac_log.size(); i++) begin
            checks++;
            if (dac_log[i] !== exp_w[i%3]) begin
                errors++;
                $display("FAIL play_word%0d got %h want %h", i, dac_log[i],
                         exp_w[i%3]);
            end
        end
        checks++;
        if (rise_log.size() < 1 || rise_log[0] - arm_cyc != 2) begin
            errors++;
            $display("FAIL play_first_lat got %0d want 2",
                     rise_log.size() > 0 ? rise_log[0] - arm_cyc : -1);
        end
        for (int i = 1; i < rise_log.size(); i++) begin
            checks++;
            if (rise_log[i] - fin_log[i-1] != 6) begin
                errors++;
                $display("FAIL play_gap%0d got %0d want 6", i,
                         rise_log[i] - fin_log[i-1]);
            end
        end
        ifc.arm = 1'b0;
        tick(1);
        checks++;
        if (ifc.finished !== 1'b0) begin
            errors++;
            $display("FAIL play_fin_drop got %b want 0", ifc.finished);
        end
    endtask

    task automatic test_continuous_abort();
        int n;
        logic saw_fin;
        clear_logs();
        ifc.loop_count = 16'd0;
        ifc.time_to_wait = 32'd1;
        ifc.arm = 1'b1;
        n = 0;
        while (dac_log.size() < 7 && n < 400) begin
            tick(1);
            n++;
        end
        checks++;
        if (dac_log.size() != 7 || ifc.dac_arm !== 1'b1) begin
            errors++;
            $display("FAIL cont_reach7 got %0d arm=%b want 7 1",
                     dac_log.size(), ifc.dac_arm);
        end
        ifc.arm = 1'b0;
        saw_fin = 1'b0;
        n = 0;
        while (n < 30) begin
            tick(1);
            if (ifc.finished === 1'b1) saw_fin = 1'b1;
            n++;
        end
        checks++;
        if (dac_log.size() != 7 || fin_log.size() != 7) begin
            errors++;
            $display("FAIL cont_xfers got %0d/%0d want 7/7",
                     dac_log.size(), fin_log.size());
        end
        checks++;
        if (saw_fin !== 1'b0 || ifc.running !== 1'b0) begin
            errors++;
            $display("FAIL cont_status got fin=%b run=%b want 0 0",
                     saw_fin, ifc.running);
        end
        checks++;
        if (ifc.loops_done !== 16'd2) begin
            errors++;
            $display("FAIL cont_loops got %0d want 2", ifc.loops_done);
        end
    endtask

    task automatic test_zero_amnt();
        int n;
        logic saw_read;
        clear_logs();
        ifc.start_addr = 32'h4000;
        ifc.word_amnt = 11'd0;
        ifc.refresh_start = 1'b1;
        saw_read = 1'b0;
        n = 0;
        while (ifc.refresh_finished !== 1'b1 && n < 20) begin
            tick(1);
            if (ifc.ram_read === 1'b1) saw_read = 1'b1;
            n++;
        end
        checks++;
        if (ifc.refresh_finished !== 1'b1 || ifc.err !== 1'b1
            || saw_read !== 1'b0) begin
            errors++;
            $display("FAIL zero_ref got fin=%b err=%b rd=%b want 1 1 0",
                     ifc.refresh_finished, ifc.err, saw_read);
        end
        ifc.refresh_start = 1'b0;
        tick(2);
        ifc.loop_count = 16'd1;
        ifc.arm = 1'b1;
        n = 0;
        while (ifc.finished !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (ifc.finished !== 1'b1 || ifc.err !== 1'b1
            || dac_log.size() != 0) begin
            errors++;
            $display("FAIL zero_arm got fin=%b err=%b n=%0d want 1 1 0",
                     ifc.finished, ifc.err, dac_log.size());
        end
        ifc.arm = 1'b0;
        tick(2);
    endtask

    task automatic test_same_cycle();
        int n;
        int c;
        clear_logs();
        ram_base = 32'h200;
        rmem[0] = 16'h0005;
        rmem[1] = 16'h0007;
        rmem[2] = 16'h0006;
        rmem[3] = 16'h0008;
        ifc.start_addr = 32'h200;
        ifc.word_amnt = 11'd2;
        ifc.loop_count = 16'd1;
        ifc.time_to_wait = 32'd0;
        ifc.refresh_start = 1'b1;
        ifc.arm = 1'b1;
        n = 0;
        while (ifc.refresh_finished !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        checks++;
        if (ifc.refresh_finished !== 1'b1 || ifc.running !== 1'b0
            || dac_log.size() != 0 || ifc.err !== 1'b0) begin
            errors++;
            $display("FAIL same_ref_first got %b%b %0d err=%b want 10 0 0",
                     ifc.refresh_finished, ifc.running, dac_log.size(),
                     ifc.err);
        end
        ifc.refresh_start = 1'b0;
        c = cyc;
        n = 0;
        while (ifc.finished !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (dac_log.size() != 2 || dac_log[0] !== 24'h170005
            || dac_log[1] !== 24'h180006) begin
            errors++;
            $display("FAIL same_words got n=%0d %h %h want 2 170005 180006",
                     dac_log.size(), dac_log[0], dac_log[1]);
        end
        checks++;
        if (rise_log.size() < 1 || rise_log[0] != c + 3) begin
            errors++;
            $display("FAIL same_start got %0d want %0d",
                     rise_log.size() > 0 ? rise_log[0] : -1, c + 3);
        end
        checks++;
        if (rise_log.size() < 2 || rise_log[1] - fin_log[0] != 2) begin
            errors++;
            $display("FAIL same_gap0 got %0d want 2",
                     rise_log.size() > 1 ? rise_log[1] - fin_log[0] : -1);
        end
        checks++;
        if (ifc.finished !== 1'b1 || ifc.loops_done !== 16'd1) begin
            errors++;
            $display("FAIL same_fin got fin=%b loops=%0d want 1 1",
                     ifc.finished, ifc.loops_done);
        end
        ifc.arm = 1'b0;
        tick(2);
    endtask

    initial begin
        rst_L = 1'b0;
        ifc.refresh_start = 1'b0;
        ifc.start_addr = '0;
        ifc.word_amnt = '0;
        ifc.arm = 1'b0;
        ifc.loop_count = '0;
        ifc.time_to_wait = '0;
        ram_base = '0;
        for (int i = 0; i < 8; i++) rmem[i] = '0;
        test_reset();
        test_reset_mid_refresh();
        test_refresh();
        test_play_loops();
        test_continuous_abort();
        test_zero_amnt();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
